// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that shares one 4-to-16 decoder among 16 requesters.
// A grant is always followed by one dead cycle, and a grant is force-released when it runs too long.
module decoder_rr_arbiter #(
  parameter int N_REQ   = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             gnt_valid,
  output logic             timeout_evt
);

  localparam int TMR_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = '1;
  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [TMR_W-1:0] tmr;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             release_now;
  logic             expire_now;

  // The first set request at or after ptr wins, wrapping past the top index back to 0.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   res;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = p + IDX_W'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    {win_found, win_idx} = rr_pick(req, ptr);
    release_now = done || !req[gnt_idx];
    expire_now  = (TIMEOUT != 0) && (tmr == TMR_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      tmr         <= '0;
      gnt_idx     <= '0;
      gnt_onehot  <= '0;
      gnt_valid   <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        GRANT: begin
          if (release_now || expire_now) begin
            // gnt_idx is held so the decoder address stays stable through the gap.
            state       <= GAP;
            gnt_valid   <= 1'b0;
            gnt_onehot  <= '0;
            timeout_evt <= !release_now;
          end else if (tmr != TMR_MAX) begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: begin
          if (enable && win_found) begin
            state      <= GRANT;
            gnt_idx    <= win_idx;
            gnt_onehot <= N_REQ'(1) << win_idx;
            gnt_valid  <= 1'b1;
            ptr        <= win_idx + IDX_W'(1);
            tmr        <= TMR_W'(1);
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
